// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx among NUM_REQ byte producers.
// Round-robin arbitration at packet granularity; the owner keeps the
// transmitter until its "last" byte has completed on the line.
// Optional build macro UART_ARB_TIMEOUT_EN adds a done-timeout watchdog
// and the timeout_err_out port.
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_IDLE    | no owner; waiting for a valid requester and tx idle
// S_SEND    | owner granted; waiting for its next byte to be valid
// S_WAIT_DONE | byte handed to uart_tx; waiting for tx_done_in
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [NUM_REQ-1:0]             req_valid_in,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data_in,
  input  logic [NUM_REQ-1:0]             req_last_in,
  output logic [NUM_REQ-1:0]             req_ready_out,
  output logic [NUM_REQ-1:0]             grant_out,
  output logic [DATA_BITS-1:0]           tx_data_out,
  output logic                           tx_start_out,
  input  logic                           tx_busy_in,
  input  logic                           tx_done_in,
  output logic                           arb_busy_out
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                           timeout_err_out
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_DONE} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 last_q, last_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 busy_q, busy_d;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic                 sel_valid;
  logic                 sel_last;
  logic [DATA_BITS-1:0] sel_data;
  logic                 tmo_hit;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 tmo_q, tmo_d;
`endif

  // Wrap-around add of an offset to a requester index.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Round-robin winner search and selection of the owner's request lines.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found && req_valid_in[wrap_add(rr_ptr_q, k)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(rr_ptr_q, k);
      end
    end
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == gidx_q) begin
        sel_valid = req_valid_in[i];
        sel_last  = req_last_in[i];
        sel_data  = req_data_in[i*DATA_BITS +: DATA_BITS];
      end
    end
`ifdef UART_ARB_TIMEOUT_EN
    tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    tmo_hit = 1'b0;
`endif
  end

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; done on the expiry cycle wins over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (win_found && !tx_busy_in) state_d = S_SEND;
      S_SEND:      if (sel_valid) state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (tx_done_in)   state_d = last_q ? S_IDLE : S_SEND;
        else if (tmo_hit) state_d = S_IDLE;
      end
      default:     state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; every output leaves through a flop.
  always_comb begin
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    last_d     = last_q;
    grant_d    = grant_q;
    ready_d    = '0;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    tmo_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (win_found && !tx_busy_in) begin
          gidx_d           = win_idx;
          grant_d[win_idx] = 1'b1;
        end
      end
      S_SEND: begin
        if (sel_valid) begin
          tx_data_d       = sel_data;
          tx_start_d      = 1'b1;
          ready_d[gidx_q] = 1'b1;
          last_d          = sel_last;
`ifdef UART_ARB_TIMEOUT_EN
          cnt_d           = '0;
`endif
        end
      end
      S_WAIT_DONE: begin
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (tx_done_in) begin
          if (last_q) begin
            grant_d  = '0;
            rr_ptr_d = gidx_q;
          end
        end else if (tmo_hit) begin
          grant_d  = '0;
          rr_ptr_d = gidx_q;
`ifdef UART_ARB_TIMEOUT_EN
          tmo_d    = 1'b1;
`endif
        end
      end
      default: grant_d = '0;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Output and datapath registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      gidx_q     <= '0;
      rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
      last_q     <= 1'b0;
      grant_q    <= '0;
      ready_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      ready_q    <= ready_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign grant_out     = grant_q;
  assign req_ready_out = ready_q;
  assign tx_data_out   = tx_data_q;
  assign tx_start_out  = tx_start_q;
  assign arb_busy_out  = busy_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_err_out = tmo_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester drivers, a uart_tx model, a packet
// level round-robin reference model feeding a scoreboard, and a monitor.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last  = '0;
  logic [N*DW-1:0] req_data  = '0;
  logic            tx_busy   = 1'b0;
  logic            tx_done   = 1'b0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    grant;
  logic [DW-1:0]   tx_data;
  logic            tx_start;
  logic            arb_busy;
`ifdef UART_ARB_TIMEOUT_EN
  logic            timeout_err;
`endif

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .req_valid_in  (req_valid),
    .req_data_in   (req_data),
    .req_last_in   (req_last),
    .req_ready_out (req_ready),
    .grant_out     (grant),
    .tx_data_out   (tx_data),
    .tx_start_out  (tx_start),
    .tx_busy_in    (tx_busy),
    .tx_done_in    (tx_done),
    .arb_busy_out  (arb_busy)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    .timeout_err_out (timeout_err)
`endif
  );

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } exp_t;

  logic [8:0] rq[N][$];
  logic [8:0] st[N][$];
  exp_t       exp_q[$];
  int         m_last = N - 1;
  int         force_stall[N];
  bit         uart_hang = 1'b0;
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  task automatic add_byte(input int r, input logic [7:0] d, input bit last);
    st[r].push_back({last, d});
  endtask

  // Reference: packets served whole, owner chosen round-robin after the last winner.
  task automatic commit_batch();
    int npk[N];
    int w;
    bit found;
    logic [8:0] b;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      npk[i] = 0;
      for (int j = 0; j < st[i].size(); j++) begin
        rq[i].push_back(st[i][j]);
        if (st[i][j][8]) npk[i]++;
      end
    end
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      w = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && npk[(m_last + k) % N] > 0) begin
          found = 1'b1;
          w = (m_last + k) % N;
        end
      end
      if (found) begin
        do begin
          b = st[w].pop_front();
          e.idx  = 2'(w);
          e.data = b[7:0];
          exp_q.push_back(e);
        end while (!b[8]);
        npk[w]--;
        m_last = w;
      end
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string name);
    int cyc = 0;
    bit ok = 1'b0;
    while (cyc < 3000 && !ok) begin
      @(negedge clk);
      cyc++;
      if (all_empty() && exp_q.size() == 0 && grant == '0 && !arb_busy && !tx_busy) ok = 1'b1;
    end
    chk(ok, name, 32'(cyc), 32'd3000);
  endtask

  // Requester k: offers its queue head; the owner may pause inside a packet.
  task automatic drive(input int k);
    int stall = 0;
    logic [8:0] cur;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        req_valid[k] = 1'b0;
        stall = 0;
      end else begin
        if (req_ready[k] && rq[k].size() > 0) begin
          cur = rq[k].pop_front();
          if (!cur[8]) begin
            if (force_stall[k] > 0) begin
              stall = force_stall[k];
              force_stall[k] = 0;
            end else if ($urandom_range(3) == 0) begin
              stall = $urandom_range(3, 1);
            end
          end
        end
        if (stall > 0 || rq[k].size() == 0) begin
          if (stall > 0) stall--;
          req_valid[k] = 1'b0;
          req_data[k*DW +: DW] = 8'($urandom);
          req_last[k] = 1'($urandom);
        end else begin
          req_valid[k] = 1'b1;
          req_data[k*DW +: DW] = rq[k][0][7:0];
          req_last[k] = rq[k][0][8];
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) force_stall[i] = 0;
    for (int i = 0; i < N; i++) begin
      automatic int k = i;
      fork
        drive(k);
      join_none
    end
  end

  // uart_tx model: busy for a few cycles after a start, then a done pulse.
  initial begin
    int ucnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && tx_start) chk(!tx_busy && !tx_done, "start_gap", {30'd0, tx_busy, tx_done}, 32'd0);
      tx_done = 1'b0;
      if (rst) begin
        tx_busy = 1'b0;
        ucnt = 0;
      end else if (tx_busy) begin
        if (ucnt == 0) begin
          tx_done = 1'b1;
          tx_busy = 1'b0;
        end else ucnt--;
      end else if (tx_start && !uart_hang) begin
        tx_busy = 1'b1;
        ucnt = $urandom_range(6, 2);
      end
    end
  end

  // Monitor: pops the scoreboard on every start pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk($onehot0(grant), "grant_onehot", 32'(grant), 32'd0);
      chk((req_ready != '0) == tx_start, "ready_with_start", 32'(req_ready), {31'd0, tx_start});
      chk(arb_busy == (grant != '0), "arb_busy", {31'd0, arb_busy}, {31'd0, grant != '0});
      if (tx_start) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_start", 32'(tx_data), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk(tx_data == e.data, "tx_data", 32'(tx_data), 32'(e.data));
          chk(grant == (4'(1) << e.idx), "grant_owner", 32'(grant), 32'(4'(1) << e.idx));
          chk(req_ready == (4'(1) << e.idx), "ready_owner", 32'(req_ready), 32'(4'(1) << e.idx));
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int cyc;
    bit seen;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk(grant == '0, "rst_grant", 32'(grant), 32'd0);
    chk(req_ready == '0, "rst_ready", 32'(req_ready), 32'd0);
    chk(!tx_start, "rst_start", {31'd0, tx_start}, 32'd0);
    chk(tx_data == '0, "rst_data", 32'(tx_data), 32'd0);
    chk(!arb_busy, "rst_busy", {31'd0, arb_busy}, 32'd0);
`ifdef UART_ARB_TIMEOUT_EN
    chk(!timeout_err, "rst_tmo", {31'd0, timeout_err}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Single byte from requester 2: grant/start latency and release.
    @(negedge clk);
    add_byte(2, 8'h5A, 1'b1);
    commit_batch();
    @(posedge clk); #2;
    chk(grant == '0, "grant_before_valid", 32'(grant), 32'd0);
    @(posedge clk); #2;
    chk(grant == 4'b0100, "grant_latency", 32'(grant), 32'h4);
    @(posedge clk); #2;
    chk(tx_start == 1'b1, "start_latency", {31'd0, tx_start}, 32'd1);
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      seen = tx_done;
    end
    chk(seen, "done_seen", 32'(cyc), 32'd100);
    chk(grant == 4'b0100, "grant_held_to_done", 32'(grant), 32'h4);
    @(posedge clk); #2;
    chk(grant == '0, "grant_release", 32'(grant), 32'd0);
    wait_idle("idle_single");

    // All four requesters, two single-byte packets each.
    for (int r = 0; r < N; r++) begin
      add_byte(r, 8'($urandom), 1'b1);
      add_byte(r, 8'($urandom), 1'b1);
    end
    commit_batch();
    wait_idle("idle_rr");

    // Three-byte packet on requester 1 against a waiting requester 2.
    add_byte(1, 8'h11, 1'b0);
    add_byte(1, 8'h22, 1'b0);
    add_byte(1, 8'h33, 1'b1);
    add_byte(2, 8'h44, 1'b1);
    commit_batch();
    wait_idle("idle_lock");

    // Owner pauses 20 cycles mid-packet.
    force_stall[0] = 20;
    add_byte(0, 8'hA0, 1'b0);
    add_byte(0, 8'hA1, 1'b0);
    add_byte(0, 8'hA2, 1'b1);
    add_byte(3, 8'hB0, 1'b1);
    commit_batch();
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      seen = req_ready[0];
    end
    chk(seen, "stall_first_byte", 32'(cyc), 32'd200);
    bad = 0;
    repeat (18) begin
      @(negedge clk);
      if (tx_start || grant != 4'b0001) bad++;
    end
    chk(bad == 0, "stall_hold", 32'(bad), 32'd0);
    wait_idle("idle_stall");

    // Random packet batches.
    repeat (8) begin
      for (int r = 0; r < N; r++) begin
        int np;
        np = $urandom_range(2);
        for (int p = 0; p < np; p++) begin
          int len;
          len = $urandom_range(4, 1);
          for (int b = 0; b < len; b++) add_byte(r, 8'($urandom), b == len - 1);
        end
      end
      commit_batch();
      wait_idle("idle_random");
    end

    // Reset in the middle of a multi-byte packet.
    add_byte(1, 8'hC1, 1'b0);
    add_byte(1, 8'hC2, 1'b0);
    add_byte(1, 8'hC3, 1'b1);
    add_byte(3, 8'hD0, 1'b1);
    commit_batch();
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      seen = tx_start && grant == 4'b0010;
    end
    chk(seen, "rst_test_start", 32'(cyc), 32'd300);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      rq[i].delete();
      st[i].delete();
      force_stall[i] = 0;
    end
    exp_q.delete();
    m_last = N - 1;
    #1;
    chk(grant == '0, "midrst_grant", 32'(grant), 32'd0);
    chk(!tx_start && req_ready == '0, "midrst_pulses", {27'd0, req_ready, tx_start}, 32'd0);
    chk(tx_data == '0 && !arb_busy, "midrst_data_busy", {23'd0, arb_busy, tx_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    add_byte(2, 8'hE2, 1'b1);
    add_byte(0, 8'hE0, 1'b1);
    commit_batch();
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      seen = grant != '0;
    end
    chk(grant == 4'b0001, "post_rst_first", 32'(grant), 32'h1);
    wait_idle("idle_post_rst");

`ifdef UART_ARB_TIMEOUT_EN
    // Transmitter never reports done: watchdog releases the owner.
    uart_hang = 1'b1;
    add_byte(1, 8'h77, 1'b1);
    add_byte(2, 8'h88, 1'b1);
    commit_batch();
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      seen = tx_start;
    end
    chk(seen, "tmo_start", 32'(cyc), 32'd100);
    uart_hang = 1'b0;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      seen = timeout_err;
    end
    chk(cyc == TMO && seen, "tmo_delay", 32'(cyc), 32'(TMO));
    chk(grant == '0, "tmo_release", 32'(grant), 32'd0);
    @(negedge clk);
    chk(!timeout_err, "tmo_pulse_width", {31'd0, timeout_err}, 32'd0);
    wait_idle("idle_tmo");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
